vram_arbiter: RTL and testbench



---
 rtl/vga_pkg.sv | 15 +
 rtl/vram_display_fetch.sv | 59 +++++
 rtl/vram_arbiter.sv | 97 +++++++++
 tb/tb_vram_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VRAM sharing logic between display refresh and CPU.
package vga_pkg;

    localparam int H_VISIBLE       = 640;
    localparam int WORDS_PER_LINE  = 80;
    localparam int PIXELS_PER_WORD = 8;
    localparam int FETCH_PHASE     = 4;
    localparam int PREFETCH_X      = 1020;

    typedef enum logic {
        IDLE = 1'b0,
        DONE = 1'b1
    } cpu_state_t;

endpackage

// File: rtl/vram_display_fetch.sv
// Display refresh side: slot decode, linear fetch address, one-word prefetch buffer and
// the 8-pixel group register seen by the pixel output stage.
module vram_display_fetch
    import vga_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int WORDS_PER_LINE = vga_pkg::WORDS_PER_LINE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            x_coord,
    input  logic                  in_vblank,
    input  logic [DATA_WIDTH-1:0] vram_rdata,
    output logic                  disp_slot,
    output logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [DATA_WIDTH-1:0] pixel_word
);

    // First x past the last slot of a line (628 + 8 = 636 for an 80-word line).
    localparam int SLOT_LIMIT = (WORDS_PER_LINE - 1) * PIXELS_PER_WORD + FETCH_PHASE;

    logic                  slot_d_reg;
    logic [ADDR_WIDTH-1:0] fetch_addr_reg;
    logic [DATA_WIDTH-1:0] next_word_reg;
    logic [DATA_WIDTH-1:0] pixel_word_reg;

    // Slot at x = 1020 fetches word 0 of a line before pixel 0 arrives.
    assign disp_slot = !in_vblank
                    && (x_coord[2:0] == 3'(FETCH_PHASE))
                    && ((x_coord == 10'(PREFETCH_X)) || (x_coord < 10'(SLOT_LIMIT)));

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_d_reg     <= 1'b0;
            fetch_addr_reg <= '0;
            next_word_reg  <= '0;
            pixel_word_reg <= '0;
        end else begin
            slot_d_reg <= disp_slot;
            if (in_vblank) begin
                fetch_addr_reg <= '0;
            end else if (slot_d_reg) begin
                fetch_addr_reg <= fetch_addr_reg + ADDR_WIDTH'(1);
            end
            // RAM data for the slot address is valid the cycle after the slot.
            if (slot_d_reg) begin
                next_word_reg <= vram_rdata;
            end
            if (!in_vblank && (x_coord[2:0] == 3'b111)) begin
                pixel_word_reg <= next_word_reg;
            end
        end
    end

    assign fetch_addr = fetch_addr_reg;
    assign pixel_word = pixel_word_reg;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display prefetch slots have absolute priority, the CPU
// takes any other cycle through a two-state req/ack FSM.
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int WORDS_PER_LINE = vga_pkg::WORDS_PER_LINE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            x_coord,
    input  logic [9:0]            y_coord,
    input  logic                  in_visible_region,
    input  logic                  in_vblank,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    output logic                  vram_we,
    output logic [DATA_WIDTH-1:0] vram_wdata,
    input  logic [DATA_WIDTH-1:0] vram_rdata,
    output logic [DATA_WIDTH-1:0] pixel_word
);

    cpu_state_t            state_reg;
    logic                  ack_reg;
    logic                  disp_slot;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  cpu_issue;
    logic                  unused_inputs;

    // Beam position beyond x and the visible flag are not needed for addressing.
    assign unused_inputs = ^{y_coord, in_visible_region};

    vram_display_fetch #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_fetch (
        .clk        (clk),
        .reset      (reset),
        .x_coord    (x_coord),
        .in_vblank  (in_vblank),
        .vram_rdata (vram_rdata),
        .disp_slot  (disp_slot),
        .fetch_addr (fetch_addr),
        .pixel_word (pixel_word)
    );

    assign cpu_issue = (state_reg == IDLE) && cpu_req && !disp_slot && !reset;

    always_comb begin
        vram_addr = '0;
        vram_we   = 1'b0;
        if (disp_slot) begin
            vram_addr = fetch_addr;
        end else if (cpu_issue) begin
            vram_addr = cpu_addr;
            vram_we   = cpu_we;
        end
    end

    assign vram_wdata = cpu_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            ack_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cpu_issue) begin
                        state_reg <= DONE;
                        ack_reg   <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    ack_reg   <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    ack_reg   <= 1'b0;
                end
            endcase
        end
    end

    // A reset landing in the DONE cycle drops the access, so the ack is masked.
    assign cpu_ack   = ack_reg & ~reset;
    assign cpu_rdata = vram_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: short frames (4 visible lines), RAM word k = k,
// beam-driven display checks plus CPU write/read, collision, reset and saturation steps.
module tb_vram_arbiter;

    localparam int AW        = 16;
    localparam int DW        = 16;
    localparam int H_TOTAL   = 656;
    localparam int VIS_LINES = 4;
    localparam int V_TOTAL   = 6;

    logic          clk;
    logic          reset;
    logic [9:0]    x_coord;
    logic [9:0]    y_coord;
    logic          in_visible_region;
    logic          in_vblank;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] vram_addr;
    logic          vram_we;
    logic [DW-1:0] vram_wdata;
    logic [DW-1:0] vram_rdata;
    logic [DW-1:0] pixel_word;

    logic [DW-1:0] mem [0:65535];

    int n_checks;
    int n_pass;
    int h;
    int v;
    int exp_fetch;
    int frame_reads;

    vram_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .WORDS_PER_LINE (80)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .x_coord           (x_coord),
        .y_coord           (y_coord),
        .in_visible_region (in_visible_region),
        .in_vblank         (in_vblank),
        .cpu_req           (cpu_req),
        .cpu_we            (cpu_we),
        .cpu_addr          (cpu_addr),
        .cpu_wdata         (cpu_wdata),
        .cpu_ack           (cpu_ack),
        .cpu_rdata         (cpu_rdata),
        .vram_addr         (vram_addr),
        .vram_we           (vram_we),
        .vram_wdata        (vram_wdata),
        .vram_rdata        (vram_rdata),
        .pixel_word        (pixel_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read single-port RAM
    always @(posedge clk) begin
        if (vram_we) mem[vram_addr] <= vram_wdata;
        vram_rdata <= mem[vram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h (line %0d h %0d)", tag, obs, exp, v, h);
        end
    endtask

    task automatic drive_beam();
        x_coord           = (h < 4) ? 10'(1020 + h) : 10'(h - 4);
        y_coord           = 10'(v);
        in_vblank         = (v >= VIS_LINES);
        in_visible_region = !in_vblank && (h >= 4) && (h < 644);
    endtask

    // One clock: advance the beam, then check display behaviour for the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        h++;
        if (h == H_TOTAL) begin
            h = 0;
            v = (v + 1) % V_TOTAL;
        end
        drive_beam();
        #1;
        if (v == 0 && h == 0) frame_reads = 0;
        if (in_vblank) exp_fetch = 0;
        // Slots sit at h = 0, 8, ..., 632 of each visible line (x = 1020, 4, ..., 628).
        if (!in_vblank && (h % 8 == 0) && (h <= 632)) begin
            check("disp_addr", 32'(vram_addr), 32'(exp_fetch));
            check("disp_we", 32'(vram_we), 32'd0);
            exp_fetch++;
            frame_reads++;
        end
        if (!in_vblank && (h >= 4) && (h < 644) && ((h - 4) % 8 == 0))
            check("pixel_word", 32'(pixel_word), 32'(v * 80 + (h - 4) / 8));
    endtask

    task automatic run_until(input int tv, input int th);
        int n;
        n = 0;
        while (!(v == tv && h == th) && n < 8000) begin
            tick();
            n++;
        end
        if (!(v == tv && h == th)) check("run_until_timeout", 32'(n), 32'd0);
    endtask

    // One CPU access in a slot-free region; lat is the expected cycles until ack.
    task automatic cpu_xfer(input string tag, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd,
                            input int lat);
        int n;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        #1;
        check({tag, "_issue_we"}, 32'(vram_we), 32'(we));
        check({tag, "_issue_addr"}, 32'(vram_addr), 32'(addr));
        n = 0;
        while (!cpu_ack && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_ack"}, 32'(cpu_ack), 32'd1);
        if (!we) check({tag, "_rdata"}, 32'(cpu_rdata), 32'(exp_rd));
        $display("cpu %s we=%0d addr=%h wdata=%h rdata=%h latency=%0d", tag, we, addr, wdata,
                 cpu_rdata, n);
        cpu_req = 1'b0;
        tick();
        check({tag, "_ack_clear"}, 32'(cpu_ack), 32'd0);
    endtask

    initial begin
        int n_acks;
        int last_ack;
        n_checks    = 0;
        n_pass      = 0;
        exp_fetch   = 0;
        frame_reads = 0;
        for (int k = 0; k < 65536; k++) mem[k] = 16'(k);
        h = 0;
        v = VIS_LINES;
        drive_beam();
        // A write request is already pending while reset is high.
        reset     = 1'b1;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 16'h0555;
        cpu_wdata = 16'h1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_vram_we", 32'(vram_we), 32'd0);
            check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        end
        check("rst_pixel_word", 32'(pixel_word), 32'd0);

        reset = 1'b0;
        #1;
        check("post_rst_issue_we", 32'(vram_we), 32'd1);
        check("post_rst_issue_addr", 32'(vram_addr), 32'h0555);
        tick();
        check("post_rst_ack", 32'(cpu_ack), 32'd1);
        $display("cpu post_reset_write addr=0555 wdata=1111 ack=%0d", cpu_ack);
        cpu_req = 1'b0;
        tick();
        check("post_rst_ack_clear", 32'(cpu_ack), 32'd0);

        cpu_xfer("wr1234", 1'b1, 16'h1234, 16'hBEEF, 16'h0000, 1);
        cpu_xfer("rd1234", 1'b0, 16'h1234, 16'h0000, 16'hBEEF, 1);
        cpu_xfer("rd0555", 1'b0, 16'h0555, 16'h0000, 16'h1111, 1);

        // Reset lands in the DONE cycle of a write.
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 16'h0777;
        cpu_wdata = 16'h2222;
        #1;
        tick();
        reset = 1'b1;
        #1;
        check("rst_mid_ack", 32'(cpu_ack), 32'd0);
        tick();
        check("rst_mid_ack_hold", 32'(cpu_ack), 32'd0);
        reset = 1'b0;
        #1;
        check("reissue_we", 32'(vram_we), 32'd1);
        tick();
        check("reissue_ack", 32'(cpu_ack), 32'd1);
        $display("cpu reissued_write addr=0777 wdata=2222 ack=%0d", cpu_ack);
        cpu_req = 1'b0;
        tick();
        check("reissue_ack_once", 32'(cpu_ack), 32'd0);
        cpu_xfer("rd0777", 1'b0, 16'h0777, 16'h0000, 16'h2222, 1);

        // Collision: request rises at x = 4 of the first visible line.
        run_until(0, 8);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h1234;
        #1;
        check("coll_slot_addr", 32'(vram_addr), 32'd1);
        check("coll_slot_ack", 32'(cpu_ack), 32'd0);
        tick();
        check("coll_issue_addr", 32'(vram_addr), 32'h1234);
        check("coll_issue_x", 32'(x_coord), 32'd5);
        check("coll_issue_ack", 32'(cpu_ack), 32'd0);
        tick();
        check("coll_ack", 32'(cpu_ack), 32'd1);
        check("coll_rdata", 32'(cpu_rdata), 32'hBEEF);
        $display("cpu collision_read addr=1234 rdata=%h ack_x=%0d", cpu_rdata, x_coord);
        cpu_req = 1'b0;
        tick();

        // Saturation over line 1: the request starts on the x = 1020 slot, so acks land
        // on every even h from 2 to 640 (each later slot coincides with a DONE cycle).
        run_until(1, 0);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h1234;
        n_acks   = 0;
        last_ack = -1;
        for (int i = 1; i <= 640; i++) begin
            tick();
            if (cpu_ack) begin
                if (last_ack < 0) check("sat_first_ack_h", 32'(h), 32'd2);
                else check("sat_gap", 32'(h - last_ack), 32'd2);
                check("sat_rdata", 32'(cpu_rdata), 32'hBEEF);
                $display("cpu saturation_read h=%0d rdata=%h", h, cpu_rdata);
                last_ack = h;
                n_acks++;
            end
        end
        cpu_req = 1'b0;
        check("sat_ack_count", 32'(n_acks), 32'd320);

        run_until(VIS_LINES, 0);
        check("frame_reads", 32'(frame_reads), 32'(VIS_LINES * 80));
        run_until(0, 0);
        check("frame2_addr0", 32'(vram_addr), 32'd0);
        run_until(0, 24);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
